// File: rtl/write_to_ddr3.sv
// write_to_ddr3: drains 128-bit video words from a show-ahead FIFO and
// writes whole frames into one of two DDR3 ping-pong buffers using 4-beat
// Avalon-MM write bursts. Each buffer has a full flag that is set when a
// frame lands in it and cleared by the downstream reader. When both
// buffers are full, the incoming frame is popped from the FIFO and thrown
// away so that the stream stays frame-aligned.
module write_to_ddr3 #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 1024
) (
  input  logic         ddr3_clk,
  input  logic         ddr3_reset_n,
  input  logic         enable,
  input  logic [127:0] src_fifo_data,
  input  logic         src_fifo_empty,
  input  logic [8:0]   src_fifo_usedw,
  output logic         src_fifo_rd,
  input  logic [25:0]  ddr3_buffer0_offset,
  input  logic [25:0]  ddr3_buffer1_offset,
  input  logic         clear_buffer0,
  input  logic         clear_buffer1,
  output logic         ddr3_wr_buffer0_full,
  output logic         ddr3_wr_buffer1_full,
  output logic         frame_dropped,
  input  logic         ddr3_avl_ready,
  output logic         ddr3_avl_burstbegin,
  output logic         ddr3_avl_write_req,
  output logic [2:0]   ddr3_avl_size,
  output logic [25:0]  ddr3_avl_addr,
  output logic [127:0] ddr3_avl_wdata,
  output logic [15:0]  ddr3_avl_be
);

  localparam int FRAME_BURSTS = (IMAGE_WIDTH * IMAGE_HEIGHT) >> 2;
  localparam int FRAME_WORDS  = 4 * FRAME_BURSTS;
  localparam int CNT_W        = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(FRAME_BURSTS - 1);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    BURST,
    DROP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             wr_sel;
  logic [CNT_W-1:0] burst_count;
  logic [CNT_W-1:0] drop_count;
  logic [1:0]       beat;
  logic [1:0]       buf_full;

  // Strobes from the control process to the datapath registers.
  logic             frame_start;
  logic             start_sel;
  logic             beat_accept;
  logic             frame_done;
  logic             drop_pop;
  logic             drop_done;

  // Write data comes straight off the FIFO head; the show-ahead FIFO holds
  // the word until it is popped, so data is stable while ready is low.
  assign ddr3_avl_wdata       = src_fifo_data;
  assign ddr3_avl_be          = '1;
  assign ddr3_wr_buffer0_full = buf_full[0];
  assign ddr3_wr_buffer1_full = buf_full[1];

  // State register.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!ddr3_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and combinational Avalon/FIFO strobes.
  always_comb begin
    // NOTE: every output of this process gets a default first, so no path
    // through the case statement can leave one unassigned (no latches).
    state_next          = state;
    ddr3_avl_write_req  = 1'b0;
    ddr3_avl_burstbegin = 1'b0;
    src_fifo_rd         = 1'b0;
    frame_start         = 1'b0;
    start_sel           = wr_sel;
    beat_accept         = 1'b0;
    frame_done          = 1'b0;
    drop_pop            = 1'b0;
    drop_done           = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          if (!buf_full[wr_sel]) begin
            frame_start = 1'b1;
            start_sel   = wr_sel;
            state_next  = WAIT_DATA;
          end else if (!buf_full[~wr_sel]) begin
            frame_start = 1'b1;
            start_sel   = ~wr_sel;
            state_next  = WAIT_DATA;
          end else begin
            state_next  = DROP;
          end
        end
      end

      // A burst only starts once all four beats are already in the FIFO.
      WAIT_DATA: begin
        if (src_fifo_usedw >= 9'd4) begin
          state_next = BURST;
        end
      end

      BURST: begin
        ddr3_avl_write_req  = 1'b1;
        ddr3_avl_burstbegin = (beat == 2'd0);
        src_fifo_rd         = ddr3_avl_ready;
        beat_accept         = ddr3_avl_ready;
        if (ddr3_avl_ready && (beat == 2'd3)) begin
          if (burst_count == LAST_BURST) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_DATA;
          end
        end
      end

      DROP: begin
        src_fifo_rd = ~src_fifo_empty;
        drop_pop    = ~src_fifo_empty;
        if (!src_fifo_empty && (drop_count == LAST_WORD)) begin
          drop_done  = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Burst address, buffer select and the beat/burst/drop counters.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      wr_sel        <= 1'b0;
      ddr3_avl_addr <= '0;
      ddr3_avl_size <= '0;
      burst_count   <= '0;
      beat          <= '0;
      drop_count    <= '0;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= drop_done;

      // Offsets are sampled only here, so mid-frame changes are ignored.
      if (frame_start) begin
        wr_sel        <= start_sel;
        ddr3_avl_addr <= start_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
        ddr3_avl_size <= 3'b100;
        burst_count   <= '0;
      end

      if (state == WAIT_DATA) begin
        beat <= '0;
      end else if (beat_accept) begin
        beat <= beat + 2'd1;
      end

      if (beat_accept && (beat == 2'd3)) begin
        if (frame_done) begin
          wr_sel <= ~wr_sel;
        end else begin
          ddr3_avl_addr <= ddr3_avl_addr + 26'd4;
          burst_count   <= burst_count + CNT_W'(1);
        end
      end

      if (drop_done) begin
        drop_count <= '0;
      end else if (drop_pop) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  // Full flags: set on frame completion, cleared by the reader; set wins.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      buf_full <= '0;
    end else begin
      if (frame_done && !wr_sel) begin
        buf_full[0] <= 1'b1;
      end else if (clear_buffer0) begin
        buf_full[0] <= 1'b0;
      end

      if (frame_done && wr_sel) begin
        buf_full[1] <= 1'b1;
      end else if (clear_buffer1) begin
        buf_full[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_write_to_ddr3.sv
// tb_write_to_ddr3: directed frame sequence with random pixel data and
// random/toggling Avalon backpressure. A FIFO model feeds the DUT, a DDR3
// memory model captures accepted beats, and a frame-level model of the
// ping-pong/full-flag rules predicts where each frame must land.
module tb_write_to_ddr3;

  localparam int IMAGE_WIDTH  = 8;
  localparam int IMAGE_HEIGHT = 2;
  localparam int FRAME_BURSTS = (IMAGE_WIDTH * IMAGE_HEIGHT) >> 2;
  localparam int FRAME_WORDS  = 4 * FRAME_BURSTS;
  localparam int OFF0         = 'h100;
  localparam int OFF1         = 'h800;

  logic         ddr3_clk;
  logic         ddr3_reset_n;
  logic         enable;
  logic [127:0] src_fifo_data;
  logic         src_fifo_empty;
  logic [8:0]   src_fifo_usedw;
  logic         src_fifo_rd;
  logic [25:0]  ddr3_buffer0_offset;
  logic [25:0]  ddr3_buffer1_offset;
  logic         clear_buffer0;
  logic         clear_buffer1;
  logic         ddr3_wr_buffer0_full;
  logic         ddr3_wr_buffer1_full;
  logic         frame_dropped;
  logic         ddr3_avl_ready;
  logic         ddr3_avl_burstbegin;
  logic         ddr3_avl_write_req;
  logic [2:0]   ddr3_avl_size;
  logic [25:0]  ddr3_avl_addr;
  logic [127:0] ddr3_avl_wdata;
  logic [15:0]  ddr3_avl_be;

  write_to_ddr3 #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) dut (
    .ddr3_clk            (ddr3_clk),
    .ddr3_reset_n        (ddr3_reset_n),
    .enable              (enable),
    .src_fifo_data       (src_fifo_data),
    .src_fifo_empty      (src_fifo_empty),
    .src_fifo_usedw      (src_fifo_usedw),
    .src_fifo_rd         (src_fifo_rd),
    .ddr3_buffer0_offset (ddr3_buffer0_offset),
    .ddr3_buffer1_offset (ddr3_buffer1_offset),
    .clear_buffer0       (clear_buffer0),
    .clear_buffer1       (clear_buffer1),
    .ddr3_wr_buffer0_full(ddr3_wr_buffer0_full),
    .ddr3_wr_buffer1_full(ddr3_wr_buffer1_full),
    .frame_dropped       (frame_dropped),
    .ddr3_avl_ready      (ddr3_avl_ready),
    .ddr3_avl_burstbegin (ddr3_avl_burstbegin),
    .ddr3_avl_write_req  (ddr3_avl_write_req),
    .ddr3_avl_size       (ddr3_avl_size),
    .ddr3_avl_addr       (ddr3_avl_addr),
    .ddr3_avl_wdata      (ddr3_avl_wdata),
    .ddr3_avl_be         (ddr3_avl_be)
  );

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  int total = 0;
  int bad   = 0;

  // FIFO model and current-frame expectation.
  logic [127:0] q[$];
  logic [127:0] frame_words[$];

  // DDR3 memory model and per-frame observations.
  logic [127:0] ddr[int];
  int           burst_addrs[$];
  int           burst_beats[$];
  int           bb_cycles[$];
  int           cur_base, cur_idx;
  int           pops, beats, req_cycles, drops, underflow;
  int           first_req_at, start_cyc, push_cyc;
  int           cyc = 0;
  bit           hold_valid;
  logic [25:0]  hold_addr;
  logic [127:0] hold_data;
  logic         hold_bb;
  int           ready_mode;     // 0: always ready, 1: toggle, 2: random
  bit           clear0_on_last;

  // Frame-level ping-pong model.
  bit           m_full[2];
  int           m_sel;
  int           exp_target;     // 0/1 buffer, -1 frame dropped
  int           exp_offset;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    src_fifo_empty = (q.size() == 0);
    src_fifo_data  = (q.size() > 0) ? q[0] : '0;
    src_fifo_usedw = 9'(q.size());
  endtask

  task automatic push_words(input int n);
    logic [127:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      q.push_back(w);
      frame_words.push_back(w);
    end
    update_fifo();
  endtask

  // One clock: drive ready, observe just after the negedge, cross the
  // posedge, then apply the FIFO pop and release single-cycle pulses.
  task automatic tick();
    logic pop;
    case (ready_mode)
      1:       ddr3_avl_ready = ~ddr3_avl_ready;
      2:       ddr3_avl_ready = 1'($urandom_range(0, 1));
      default: ddr3_avl_ready = 1'b1;
    endcase
    #1;
    pop = src_fifo_rd;
    if (hold_valid) begin
      chk("hold_req",  ddr3_avl_write_req,  1'b1);
      chk("hold_addr", ddr3_avl_addr,       hold_addr);
      chk("hold_data", ddr3_avl_wdata,      hold_data);
      chk("hold_bb",   ddr3_avl_burstbegin, hold_bb);
      hold_valid = 1'b0;
    end
    if (ddr3_avl_write_req) begin
      req_cycles++;
      if (first_req_at < 0) first_req_at = cyc;
      chk("rd_vs_ready", pop, ddr3_avl_ready);
      if (!ddr3_avl_ready) begin
        hold_valid = 1'b1;
        hold_addr  = ddr3_avl_addr;
        hold_data  = ddr3_avl_wdata;
        hold_bb    = ddr3_avl_burstbegin;
      end else begin
        chk("size", ddr3_avl_size, 3'b100);
        chk("be",   ddr3_avl_be,   16'hffff);
        if (ddr3_avl_burstbegin) begin
          if (cur_idx > 0) burst_beats.push_back(cur_idx);
          cur_base = int'(ddr3_avl_addr);
          cur_idx  = 0;
          burst_addrs.push_back(cur_base);
          bb_cycles.push_back(cyc);
        end
        ddr[cur_base + cur_idx] = ddr3_avl_wdata;
        cur_idx++;
        beats++;
        if (clear0_on_last && beats == FRAME_WORDS) clear_buffer0 = 1'b1;
      end
    end
    if (pop) begin
      pops++;
      if (q.size() == 0) underflow++;
    end
    if (frame_dropped) drops++;
    @(posedge ddr3_clk);
    @(negedge ddr3_clk);
    clear_buffer0 = 1'b0;
    clear_buffer1 = 1'b0;
    enable        = 1'b0;
    if (pop && q.size() > 0) void'(q.pop_front());
    update_fifo();
    cyc++;
  endtask

  task automatic start_frame();
    pops = 0; beats = 0; req_cycles = 0; drops = 0; underflow = 0;
    cur_idx = 0; cur_base = 0; first_req_at = -1; hold_valid = 1'b0;
    burst_addrs.delete();
    burst_beats.delete();
    bb_cycles.delete();
    ddr.delete();
    if (!m_full[m_sel]) begin
      exp_target = m_sel;
    end else if (!m_full[m_sel ^ 1]) begin
      exp_target = m_sel ^ 1;
      m_sel      = exp_target;
    end else begin
      exp_target = -1;
    end
    exp_offset = (exp_target == 1) ? OFF1 : OFF0;
    start_cyc  = cyc;
    enable     = 1'b1;
    tick();
  endtask

  task automatic finish_frame(input string name, input bit glitch);
    int n = 0;
    if (exp_target >= 0) begin
      while (beats < FRAME_WORDS && n < 600) begin
        if (glitch && burst_addrs.size() == 2) ddr3_buffer1_offset = 26'h3000;
        tick();
        n++;
      end
      chk({name, "_timeout"}, 1'(beats >= FRAME_WORDS), 1'b1);
      tick();
      tick();
      ddr3_buffer1_offset = 26'(OFF1);
      if (cur_idx > 0) burst_beats.push_back(cur_idx);
      chk({name, "_nbursts"}, burst_addrs.size(), FRAME_BURSTS);
      for (int k = 0; k < burst_addrs.size(); k++)
        chk({name, "_addr"}, burst_addrs[k], exp_offset + 4 * k);
      for (int k = 0; k < burst_beats.size(); k++)
        chk({name, "_beats_per_burst"}, burst_beats[k], 4);
      chk({name, "_beats"}, beats, FRAME_WORDS);
      chk({name, "_pops"},  pops,  FRAME_WORDS);
      for (int i = 0; i < FRAME_WORDS; i++)
        chk({name, "_mem"}, ddr.exists(exp_offset + i) ? ddr[exp_offset + i] : 'x,
            frame_words[i]);
      m_full[exp_target] = 1'b1;
      m_sel              = exp_target ^ 1;
    end else begin
      while (drops == 0 && n < 600) begin
        tick();
        n++;
      end
      chk({name, "_timeout"}, 1'(drops > 0), 1'b1);
      repeat (3) tick();
      chk({name, "_drop_pulses"}, drops,      1);
      chk({name, "_no_write"},    req_cycles, 0);
      chk({name, "_pops"},        pops,       FRAME_WORDS);
    end
    chk({name, "_full0"},     ddr3_wr_buffer0_full, m_full[0]);
    chk({name, "_full1"},     ddr3_wr_buffer1_full, m_full[1]);
    chk({name, "_underflow"}, underflow, 0);
    chk({name, "_fifo_left"}, q.size(), 0);
    frame_words.delete();
  endtask

  task automatic pulse_clear(input string name, input int n);
    if (n == 0) clear_buffer0 = 1'b1;
    else        clear_buffer1 = 1'b1;
    m_full[n] = 1'b0;
    tick();
    chk({name, "_full0"}, ddr3_wr_buffer0_full, m_full[0]);
    chk({name, "_full1"}, ddr3_wr_buffer1_full, m_full[1]);
  endtask

  initial begin
    ddr3_reset_n        = 1'b0;
    enable              = 1'b0;
    clear_buffer0       = 1'b0;
    clear_buffer1       = 1'b0;
    ddr3_avl_ready      = 1'b1;
    ddr3_buffer0_offset = 26'(OFF0);
    ddr3_buffer1_offset = 26'(OFF1);
    ready_mode          = 0;
    clear0_on_last      = 1'b0;
    m_full              = '{1'b0, 1'b0};
    m_sel               = 0;
    update_fifo();
    repeat (3) @(negedge ddr3_clk);

    // Reset state.
    chk("rst_addr",   ddr3_avl_addr,        26'd0);
    chk("rst_size",   ddr3_avl_size,        3'd0);
    chk("rst_full0",  ddr3_wr_buffer0_full, 1'b0);
    chk("rst_full1",  ddr3_wr_buffer1_full, 1'b0);
    chk("rst_drop",   frame_dropped,        1'b0);
    chk("rst_req",    ddr3_avl_write_req,   1'b0);
    chk("rst_bb",     ddr3_avl_burstbegin,  1'b0);
    chk("rst_rd",     src_fifo_rd,          1'b0);
    chk("rst_be",     ddr3_avl_be,          16'hffff);
    ddr3_reset_n = 1'b1;
    @(negedge ddr3_clk);

    // Basic frame into buffer 0, plus start latency and burst spacing.
    push_words(FRAME_WORDS);
    start_frame();
    finish_frame("f1_basic", 1'b0);
    chk("f1_latency_ge2", 1'((first_req_at - start_cyc) >= 2), 1'b1);
    for (int k = 1; k < bb_cycles.size(); k++)
      chk("f1_burst_gap", bb_cycles[k] - bb_cycles[k - 1], 5);

    // Ping-pong: second frame lands in buffer 1.
    push_words(FRAME_WORDS);
    start_frame();
    finish_frame("f2_pingpong", 1'b0);

    // Both full: frame is drained, with a FIFO gap mid-frame.
    push_words(10);
    start_frame();
    repeat (5) tick();
    push_words(FRAME_WORDS - 10);
    finish_frame("f3_drop", 1'b0);

    // Clear handling, including a redundant clear.
    pulse_clear("clr1", 1);
    pulse_clear("clr1_again", 1);

    // Backpressure toggling every cycle; offset change mid-frame ignored.
    ready_mode = 1;
    push_words(FRAME_WORDS);
    start_frame();
    finish_frame("f4_backpressure", 1'b1);

    // Same-cycle set and clear of buffer 0: set wins.
    pulse_clear("clr0", 0);
    ready_mode     = 2;
    clear0_on_last = 1'b1;
    push_words(FRAME_WORDS);
    start_frame();
    finish_frame("f5_setwins", 1'b0);
    clear0_on_last = 1'b0;
    chk("f5_full0_set_wins", ddr3_wr_buffer0_full, 1'b1);

    // FIFO starvation: three words never start a burst.
    pulse_clear("clr1_b", 1);
    ready_mode = 0;
    push_words(3);
    start_frame();
    repeat (8) tick();
    chk("f6_starve_noreq", req_cycles, 0);
    push_words(FRAME_WORDS - 3);
    push_cyc = cyc;
    tick();
    tick();
    chk("f6_start_next", first_req_at, push_cyc + 1);
    ready_mode = 2;
    finish_frame("f6_starve", 1'b0);

    // Reset in the middle of a burst at beat 2.
    pulse_clear("clr0_b", 0);
    ready_mode = 0;
    push_words(FRAME_WORDS);
    start_frame();
    for (int n = 0; n < 50 && beats < 2; n++) tick();
    chk("f7_reached_beat2", beats, 2);
    ddr3_reset_n = 1'b0;
    #1;
    chk("f7_rst_addr",  ddr3_avl_addr,        26'd0);
    chk("f7_rst_size",  ddr3_avl_size,        3'd0);
    chk("f7_rst_full0", ddr3_wr_buffer0_full, 1'b0);
    chk("f7_rst_full1", ddr3_wr_buffer1_full, 1'b0);
    chk("f7_rst_drop",  frame_dropped,        1'b0);
    chk("f7_rst_req",   ddr3_avl_write_req,   1'b0);
    chk("f7_rst_bb",    ddr3_avl_burstbegin,  1'b0);
    chk("f7_rst_rd",    src_fifo_rd,          1'b0);
    @(posedge ddr3_clk);
    @(negedge ddr3_clk);
    ddr3_reset_n = 1'b1;
    q.delete();
    frame_words.delete();
    update_fifo();
    m_full = '{1'b0, 1'b0};
    m_sel  = 0;

    // Fresh frame after reset restarts at buffer 0 offset.
    ready_mode = 2;
    push_words(FRAME_WORDS);
    start_frame();
    finish_frame("f8_after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
